// File: rtl/mem_lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package mem_lsu_pkg;

  // Store width on mem_write
  localparam logic [1:0] MW_IDLE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;

  // Load type on funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int TIMEOUT_DEFAULT = 255;

  // Request fields captured when an access is accepted
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  // Stores take precedence over loads when both are requested.
  function automatic logic is_aligned(input logic [1:0] mw, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (mw != MW_IDLE) begin
      case (mw)
        MW_BYTE: ok = 1'b1;
        MW_HALF: ok = ~off[0];
        default: ok = (off == 2'b00);
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: ok = 1'b1;
        F3_LH, F3_LHU: ok = ~off[0];
        default:       ok = (off == 2'b00);
      endcase
    end
    return ok;
  endfunction

  function automatic logic [3:0] wstrb_of(input logic [1:0] mw, input logic [1:0] off);
    logic [3:0] s;
    case (mw)
      MW_BYTE: s = 4'b0001 << off;
      MW_HALF: s = 4'b0011 << {off[1], 1'b0};
      MW_WORD: s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] mw, input logic [31:0] sd);
    logic [31:0] d;
    case (mw)
      MW_BYTE: d = {4{sd[7:0]}};
      MW_HALF: d = {2{sd[15:0]}};
      MW_WORD: d = sd;
      default: d = 32'h0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Pipeline-side and bus-side signals of the load/store unit.
interface mem_lsu_if;
  logic        mem_read;
  logic [1:0]  mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  // Environment view: drives requests and bus responses
  modport master (
    output mem_read, mem_write, funct3, addr, store_data, bus_rdata, bus_ack,
    input  load_data, stall, misalign, bus_err, bus_req, bus_we, bus_addr,
           bus_wstrb, bus_wdata
  );

  // LSU view
  modport slave (
    input  mem_read, mem_write, funct3, addr, store_data, bus_rdata, bus_ack,
    output load_data, stall, misalign, bus_err, bus_req, bus_we, bus_addr,
           bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/mem_lsu_load_extend.sv
// Lane select and sign/zero extension of a bus read word.
module load_extend
  import mem_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_byte_off,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte/halfword, then extend according to load type
  always_comb begin
    w_byte = 8'h0;
    w_half = 16'h0;
    case (i_byte_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_byte_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'h0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'h0, w_half};
      default: o_data = i_rdata;   // LW and undefined codes pass the word through
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: accepts one access from the MEM stage, runs it on a
// single-outstanding word bus with timeout, returns the extended load result.
//
//   state | meaning
//   IDLE  | waiting for an access; aligned ones are captured, misaligned pulse misalign
//   REQ   | bus_req held with stable fields until bus_ack or timeout
//   DONE  | one-cycle result slot (load_data / bus_err), no new access taken
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic         clk,
  input logic         rst_n,
  mem_lsu_if.slave    bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  req_t        r_req;
  logic [31:0] r_rdata;
  logic [7:0]  r_cnt;
  logic        r_err;

  logic        w_is_write;
  logic        w_access;
  logic        w_aligned;
  logic        w_accept;
  logic        w_timeout;
  logic [31:0] w_ext;

  assign w_is_write = (bus.mem_write != MW_IDLE);
  assign w_access   = w_is_write | bus.mem_read;
  assign w_aligned  = is_aligned(bus.mem_write, bus.funct3, bus.addr[1:0]);
  assign w_accept   = (r_state == ST_IDLE) & w_access & w_aligned;
  assign w_timeout  = (r_state == ST_REQ) & ~bus.bus_ack & (r_cnt == CNT_LAST);

  load_extend u_load_extend (
    .i_rdata    (r_rdata),
    .i_funct3   (r_req.funct3),
    .i_byte_off (r_req.addr[1:0]),
    .o_data     (w_ext)
  );

  // Next-state selection
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_REQ;
      ST_REQ:  if (bus.bus_ack || w_timeout) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, captured request, read data and wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_rdata <= 32'h0;
      r_cnt   <= 8'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req.we     <= w_is_write;
            r_req.funct3 <= bus.funct3;
            r_req.addr   <= bus.addr;
            r_req.wstrb  <= wstrb_of(bus.mem_write, bus.addr[1:0]);
            r_req.wdata  <= wdata_of(bus.mem_write, bus.store_data);
            r_cnt        <= 8'h0;
            r_err        <= 1'b0;
          end
        end
        ST_REQ: begin
          if (bus.bus_ack) begin
            r_rdata <= bus.bus_rdata;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus fields are only driven while the request is outstanding
  assign bus.bus_req   = (r_state == ST_REQ);
  assign bus.bus_we    = (r_state == ST_REQ) & r_req.we;
  assign bus.bus_addr  = (r_state == ST_REQ) ? {r_req.addr[31:2], 2'b00} : 32'h0;
  assign bus.bus_wstrb = (r_state == ST_REQ) ? r_req.wstrb : 4'h0;
  assign bus.bus_wdata = (r_state == ST_REQ) ? r_req.wdata : 32'h0;

  assign bus.stall     = w_accept | (r_state == ST_REQ);
  assign bus.misalign  = (r_state == ST_IDLE) & w_access & ~w_aligned;
  assign bus.bus_err   = (r_state == ST_DONE) & r_err;
  assign bus.load_data = ((r_state == ST_DONE) && !r_req.we && !r_err) ? w_ext : 32'h0;

endmodule
